// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus an optional iterative
// shift-add multiplier (one multiplier bit per cycle) enabled by ALU_EXEC_MUL_EN.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] alu_res;
  logic             slt_bit;
  logic             accept;
  logic             is_mul_op;

  assign accept  = start_i && !busy_o;
  assign slt_bit = $signed(src1_i) < $signed(src2_i);

  always_comb begin
    alu_res = '0;
    case (ctrl_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_ADD:  alu_res = src1_i + src2_i;
      OP_SUB:  alu_res = src1_i - src2_i;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mul_start;
  logic             mul_last;

  assign is_mul_op = (ctrl_i == OP_MUL);
  assign mul_start = accept && is_mul_op;
  assign mul_last  = (state_q == MUL) && (cnt_q == CW'(WIDTH - 1));
  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = MUL;
      MUL:     if (mul_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == MUL);
  end

  // Partial products live only in these registers; result_o moves at completion.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (mul_start) begin
      mcand_d  = src1_i;
      mplier_d = src2_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (state_q == MUL) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_next;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  assign is_mul_op = 1'b0;
  assign busy_o    = 1'b0;
`endif

  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    if (accept && !is_mul_op) begin
      result_d = alu_res;
      zero_d   = (alu_res == '0);
      done_d   = 1'b1;
    end
`ifdef ALU_EXEC_MUL_EN
    if (mul_last) begin
      result_d = acc_next;
      zero_d   = (acc_next == '0);
      done_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; MUL checks follow
// whether ALU_EXEC_MUL_EN is defined for the build.
module tb_alu_exec_unit;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  ctrl_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        zero_o;

  int testCount = 0;
  int failCount = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .ctrl_i   (ctrl_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .zero_o   (zero_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One accepted single-cycle op: drive on a falling edge, check one cycle later.
  task automatic applyStimulus(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expected);
    @(negedge clk_i);
    start_i = 1'b1;
    ctrl_i  = ctrl;
    src1_i  = a;
    src2_i  = b;
    @(negedge clk_i);
    start_i = 1'b0;
    checkOutput({tag, "_done"}, 32'(done_o), 32'd1);
    checkOutput({tag, "_result"}, result_o, expected);
    checkOutput({tag, "_zero"}, 32'(zero_o), 32'(expected == 32'd0));
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  logic [3:0]  b2bCtrl [3] = '{4'b0000, 4'b0001, 4'b0110};
  logic [31:0] b2bExp  [3] = '{32'h30, 32'hFC, 32'hB4};

  initial begin
    rst_i   = 1'b0;
    start_i = 1'b0;
    ctrl_i  = 4'b0000;
    src1_i  = '0;
    src2_i  = '0;

    // Start asserted during reset must not be accepted.
    repeat (2) @(negedge clk_i);
    start_i = 1'b1;
    ctrl_i  = 4'b0010;
    src1_i  = 32'd4;
    src2_i  = 32'd4;
    @(negedge clk_i);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_result", result_o, 32'd0);
    checkOutput("rst_zero", 32'(zero_o), 32'd1);
    start_i = 1'b0;
    rst_i   = 1'b1;
    @(negedge clk_i);
    checkOutput("post_rst_done", 32'(done_o), 32'd0);

    applyStimulus("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0);
    @(negedge clk_i);
    checkOutput("add_wrap_pulse_end", 32'(done_o), 32'd0);
    checkOutput("add_wrap_hold", result_o, 32'd0);

    applyStimulus("slt_neg_lt", 4'b0111, 32'hFFFF_FFFE, 32'd3, 32'd1);
    applyStimulus("slt_swap", 4'b0111, 32'd3, 32'hFFFF_FFFE, 32'd0);
    applyStimulus("sub_wrap", 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF);
    applyStimulus("unknown", 4'b0011, 32'd9, 32'd9, 32'd0);
    applyStimulus("add_small", 4'b0010, 32'd2, 32'd3, 32'd5);

`ifndef ALU_EXEC_MUL_EN
    applyStimulus("mul_off", 4'b1000, 32'd7, 32'd6, 32'd0);
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("mul_off_busy", 32'(busy_o), 32'd0);
    end
`endif

    @(negedge clk_i);
    start_i = 1'b1;
    src1_i  = 32'hF0;
    src2_i  = 32'h3C;
    for (int i = 0; i < 3; i++) begin
      ctrl_i = b2bCtrl[i];
      @(negedge clk_i);
      checkOutput($sformatf("b2b_done%0d", i), 32'(done_o), 32'd1);
      checkOutput($sformatf("b2b_result%0d", i), result_o, b2bExp[i]);
    end
    start_i = 1'b0;
    @(negedge clk_i);
    checkOutput("b2b_pulse_end", 32'(done_o), 32'd0);

`ifdef ALU_EXEC_MUL_EN
    begin
      int busyCycles;
      int doneSeen;
      busyCycles = 0;
      doneSeen   = 0;
      start_i = 1'b1;
      ctrl_i  = 4'b1000;
      src1_i  = 32'd7;
      src2_i  = 32'd6;
      @(negedge clk_i);
      ctrl_i = 4'b0001;
      for (int k = 0; k < 32; k++) begin
        if (busy_o) busyCycles++;
        if (done_o) doneSeen++;
        if (k == 0 || k == 31) checkOutput("mul_result_held", result_o, 32'hB4);
        @(negedge clk_i);
      end
      start_i = 1'b0;
      checkOutput("mul_busy_cycles", 32'(busyCycles), 32'd32);
      checkOutput("mul_early_done", 32'(doneSeen), 32'd0);
      checkOutput("mul_done", 32'(done_o), 32'd1);
      checkOutput("mul_result", result_o, 32'd42);
      checkOutput("mul_zero", 32'(zero_o), 32'd0);
      checkOutput("mul_busy_clear", 32'(busy_o), 32'd0);
      @(negedge clk_i);
      checkOutput("mul_pulse_end", 32'(done_o), 32'd0);
      checkOutput("mul_or_ignored", result_o, 32'd42);

      start_i = 1'b1;
      ctrl_i  = 4'b1000;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (9) @(negedge clk_i);
      checkOutput("mul_inflight_busy", 32'(busy_o), 32'd1);
    end
`endif

    // Asynchronous reset between clock edges clears everything at once.
    #2 rst_i = 1'b0;
    #1;
    checkOutput("async_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("async_rst_result", result_o, 32'd0);
    checkOutput("async_rst_zero", 32'(zero_o), 32'd1);
    checkOutput("async_rst_done", 32'(done_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      checkOutput("after_rst_no_done", 32'(done_o), 32'd0);
      checkOutput("after_rst_busy", 32'(busy_o), 32'd0);
    end

    applyStimulus("add_after_rst", 4'b0010, 32'd2, 32'd3, 32'd5);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
